// File: rtl/dma_mem_pkg.sv
// dma_mem_pkg: shared types and constants for the DMA memory responder
package dma_mem_pkg;
   localparam int WORD_W       = 32;
   localparam int BE_W         = WORD_W / 8;
   localparam int SECTOR_BYTES = 512;
   typedef enum logic [1:0] {IDLE, REQ, DONE} op_state_t;
endpackage

// File: rtl/dma_buf_dpram.sv
// dma_buf_dpram: true dual-port sector buffer, byte enables on port a, registered read data
module dma_buf_dpram
   import dma_mem_pkg::*;
#(
   parameter int ADDR_W = 7
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic              a_rd,
   input  logic              a_wr,
   input  logic [BE_W-1:0]   a_be,
   input  logic [WORD_W-1:0] a_wdata,
   output logic [WORD_W-1:0] a_rdata,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic              b_rd,
   input  logic              b_wr,
   input  logic [WORD_W-1:0] b_wdata,
   output logic [WORD_W-1:0] b_rdata
);
   logic [WORD_W-1:0] ram [2**ADDR_W];
   always_ff @(posedge clk_sys) begin
      if (a_wr)
         for (int i = 0; i < BE_W; i++)
            if (a_be[i]) ram[a_addr][8*i +: 8] <= a_wdata[8*i +: 8];
      if (b_wr) ram[b_addr] <= b_wdata;
      if (a_rd) a_rdata <= ram[a_addr];
   end
   // a simultaneous core write wins and leaves the previous read data visible
   always_ff @(posedge clk_sys or posedge reset)
      if (reset) b_rdata <= '0;
      else if (b_rd && !b_wr) b_rdata <= ram[b_addr];
endmodule

// File: rtl/dma_mem_responder.sv
// dma_mem_responder: Avalon-MM slave onto the sector buffer, core-side port,
// and the disk-op handshake toward the HPS with timeout.
module dma_mem_responder
   import dma_mem_pkg::*;
#(
   parameter int          ADDR_W      = 7,
   parameter int          READ_LAT    = 2,
   parameter int unsigned TIMEOUT_CYC = 2**24
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic [31:0]       mem_address,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [WORD_W-1:0] mem_writedata,
   input  logic [BE_W-1:0]   mem_byteenable,
   input  logic              mem_burstcount,
   output logic              mem_waitrequest,
   output logic [WORD_W-1:0] mem_readdata,
   output logic              mem_readdatavalid,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic              core_rd,
   input  logic              core_wr,
   input  logic [WORD_W-1:0] core_wdata,
   output logic [WORD_W-1:0] core_rdata,
   input  logic              op_start,
   input  logic              op_write,
   input  logic              op_device,
   output logic              disk_op_read,
   output logic              disk_op_write,
   output logic              disk_op_device,
   input  logic              disk_result_ok,
   input  logic              disk_result_error,
   output logic              op_done,
   output logic              op_err,
   output logic              oor_flag
);
   localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC - 1);
   logic              core_req, wr_acc, rd_acc, oor, rd_oor;
   logic [WORD_W-1:0] ram_rdata;
   logic [READ_LAT-1:0] vld;
   logic [WORD_W-1:0] dq [READ_LAT-1];
   op_state_t         state, state_n;
   logic              dir, dir_n, dev, dev_n, err, err_n;
   logic [31:0]       cnt, cnt_n;
   assign core_req        = core_rd | core_wr;
   assign mem_waitrequest = (mem_read | mem_write) & core_req;
   assign wr_acc          = mem_write & ~core_req;
   assign rd_acc          = mem_read & ~mem_write & ~core_req;
   assign oor             = |mem_address[31:ADDR_W+2];
   dma_buf_dpram #(.ADDR_W(ADDR_W)) u_buf (
      .clk_sys (clk_sys),
      .reset   (reset),
      .a_addr  (mem_address[ADDR_W+1:2]),
      .a_rd    (rd_acc),
      .a_wr    (wr_acc & ~oor),
      .a_be    (mem_byteenable),
      .a_wdata (mem_writedata),
      .a_rdata (ram_rdata),
      .b_addr  (core_addr),
      .b_rd    (core_rd),
      .b_wr    (core_wr),
      .b_wdata (core_wdata),
      .b_rdata (core_rdata)
   );
   // RAM register is stage 1; dq carries the remaining READ_LAT-1 stages
   always_ff @(posedge clk_sys or posedge reset)
      if (reset) begin
         vld      <= '0;
         rd_oor   <= 1'b0;
         oor_flag <= 1'b0;
         for (int i = 0; i < READ_LAT-1; i++) dq[i] <= '0;
      end else begin
         vld    <= {vld[READ_LAT-2:0], rd_acc};
         rd_oor <= oor;
         dq[0]  <= rd_oor ? '0 : ram_rdata;
         for (int i = 1; i < READ_LAT-1; i++) dq[i] <= dq[i-1];
         if ((wr_acc | rd_acc) & (oor | ~mem_burstcount)) oor_flag <= 1'b1;
      end
   assign mem_readdatavalid = vld[READ_LAT-1];
   assign mem_readdata      = dq[READ_LAT-2];
   always_ff @(posedge clk_sys or posedge reset)
      if (reset) begin
         state <= IDLE;
         dir   <= 1'b0;
         dev   <= 1'b0;
         err   <= 1'b0;
         cnt   <= '0;
      end else begin
         state <= state_n;
         dir   <= dir_n;
         dev   <= dev_n;
         err   <= err_n;
         cnt   <= cnt_n;
      end
   always_comb begin
      state_n = state;
      dir_n   = dir;
      dev_n   = dev;
      err_n   = err;
      cnt_n   = cnt;
      case (state)
         IDLE: if (op_start) begin
            state_n = REQ;
            dir_n   = op_write;
            dev_n   = op_device;
            cnt_n   = '0;
         end
         REQ: begin
            cnt_n = cnt + 32'd1;
            if (disk_result_ok | disk_result_error) begin
               state_n = DONE;
               err_n   = disk_result_error;
            end else if (TIMEOUT_CYC != 0 && cnt == TO_LAST) begin
               state_n = DONE;
               err_n   = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end
   assign disk_op_read   = (state == REQ) & ~dir;
   assign disk_op_write  = (state == REQ) & dir;
   assign disk_op_device = dev;
   assign op_done        = state == DONE;
   assign op_err         = op_done & err;
endmodule

// File: tb/tb_dma_mem_responder.sv
// tb_dma_mem_responder: scenario tasks checked against a word-array buffer model
// and cycle-count expectations for the disk-op handshake.
module tb_dma_mem_responder;
   logic        clk_sys = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] mem_address, mem_writedata, core_wdata;
   logic        mem_read, mem_write, mem_burstcount;
   logic [3:0]  mem_byteenable;
   logic [6:0]  core_addr;
   logic        core_rd, core_wr, op_start, op_write, op_device, disk_result_ok, disk_result_error;
   logic        mem_waitrequest, mem_readdatavalid, disk_op_read, disk_op_write, disk_op_device;
   logic        op_done, op_err, oor_flag;
   logic [31:0] mem_readdata, core_rdata;
   logic        t_mem_waitrequest, t_mem_readdatavalid, t_disk_op_read, t_disk_op_write, t_disk_op_device;
   logic        t_op_done, t_op_err, t_oor_flag;
   logic [31:0] t_mem_readdata, t_core_rdata;
   int          errors = 0;
   int          checks = 0;
   logic [31:0] ref_mem [128];
   logic [31:0] exp_crd;

   always #5 clk_sys = ~clk_sys;

   dma_mem_responder #(.TIMEOUT_CYC(1000)) u_dut (
      .clk_sys(clk_sys), .reset(reset), .mem_address(mem_address), .mem_read(mem_read),
      .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
      .mem_burstcount(mem_burstcount), .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata),
      .mem_readdatavalid(mem_readdatavalid), .core_addr(core_addr), .core_rd(core_rd), .core_wr(core_wr),
      .core_wdata(core_wdata), .core_rdata(core_rdata), .op_start(op_start), .op_write(op_write),
      .op_device(op_device), .disk_op_read(disk_op_read), .disk_op_write(disk_op_write),
      .disk_op_device(disk_op_device), .disk_result_ok(disk_result_ok), .disk_result_error(disk_result_error),
      .op_done(op_done), .op_err(op_err), .oor_flag(oor_flag));

   dma_mem_responder #(.TIMEOUT_CYC(16)) u_to (
      .clk_sys(clk_sys), .reset(reset), .mem_address(mem_address), .mem_read(mem_read),
      .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
      .mem_burstcount(mem_burstcount), .mem_waitrequest(t_mem_waitrequest), .mem_readdata(t_mem_readdata),
      .mem_readdatavalid(t_mem_readdatavalid), .core_addr(core_addr), .core_rd(core_rd), .core_wr(core_wr),
      .core_wdata(core_wdata), .core_rdata(t_core_rdata), .op_start(op_start), .op_write(op_write),
      .op_device(op_device), .disk_op_read(t_disk_op_read), .disk_op_write(t_disk_op_write),
      .disk_op_device(t_disk_op_device), .disk_result_ok(disk_result_ok), .disk_result_error(disk_result_error),
      .op_done(t_op_done), .op_err(t_op_err), .oor_flag(t_oor_flag));

   function automatic logic in_range(input logic [31:0] a);
      return a[31:9] == 23'd0;
   endfunction

   function automatic logic [31:0] ref_read(input logic [31:0] a);
      return in_range(a) ? ref_mem[a[8:2]] : 32'h0;
   endfunction

   task automatic ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      if (in_range(a))
         for (int b = 0; b < 4; b++)
            if (be[b]) ref_mem[a[8:2]][8*b +: 8] = d[8*b +: 8];
   endtask

   task automatic idle();
      mem_read = 0; mem_write = 0; mem_address = 0; mem_writedata = 0;
      mem_byteenable = 4'hF; mem_burstcount = 1;
      core_rd = 0; core_wr = 0; core_addr = 0; core_wdata = 0;
      op_start = 0; op_write = 0; op_device = 0; disk_result_ok = 0; disk_result_error = 0;
   endtask

   task automatic next_cycle();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic test_reset();
      idle();
      reset = 1;
      repeat (2) @(posedge clk_sys);
      #1;
      @(negedge clk_sys);
      checks++;
      if ({mem_waitrequest, mem_readdatavalid, disk_op_read, disk_op_write, disk_op_device, op_done, op_err, oor_flag} !== 8'h0)
         begin errors++; $display("FAIL reset_ctl: got %b expected 00000000",
            {mem_waitrequest, mem_readdatavalid, disk_op_read, disk_op_write, disk_op_device, op_done, op_err, oor_flag}); end
      checks++;
      if (mem_readdata !== 32'h0) begin errors++; $display("FAIL reset_readdata: got %h expected 0", mem_readdata); end
      checks++;
      if (core_rdata !== 32'h0) begin errors++; $display("FAIL reset_core_rdata: got %h expected 0", core_rdata); end
      reset = 0;
      next_cycle();
   endtask

   task automatic test_fill();
      for (int i = 0; i < 128; i++) begin
         core_wr = 1; core_addr = 7'(i); core_wdata = 32'(i * 3);
         ref_mem[i] = 32'(i * 3);
         next_cycle();
      end
      core_wr = 0;
   endtask

   task automatic test_byte_enable();
      mem_write = 1; mem_address = 32'h10; mem_writedata = 32'h1234_5678; mem_byteenable = 4'b0011;
      ref_write(mem_address, mem_writedata, mem_byteenable);
      next_cycle();
      mem_write = 0; mem_read = 1; mem_byteenable = 4'hF;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk_sys);
         checks++;
         if (mem_readdatavalid !== (k == 2)) begin errors++;
            $display("FAIL be_valid[%0d]: got %b expected %b", k, mem_readdatavalid, k == 2); end
         if (k == 2) begin
            checks++;
            if (mem_readdata !== 32'h0000_5678) begin errors++;
               $display("FAIL be_data: got %h expected 00005678", mem_readdata); end
         end
         next_cycle();
         mem_read = 0;
      end
   endtask

   task automatic test_back_to_back();
      core_wr = 1; core_addr = 7'd4; core_wdata = 32'd12; ref_mem[4] = 32'd12;
      next_cycle();
      core_wr = 0;
      for (int c = 0; c < 131; c++) begin
         mem_read = c < 128;
         mem_address = 32'((c % 128) * 4);
         @(negedge clk_sys);
         checks++;
         if (mem_readdatavalid !== (c >= 2 && c < 130)) begin errors++;
            $display("FAIL b2b_valid[%0d]: got %b expected %b", c, mem_readdatavalid, c >= 2 && c < 130); end
         if (c >= 2 && c < 130) begin
            checks++;
            if (mem_readdata !== 32'((c - 2) * 3)) begin errors++;
               $display("FAIL b2b_data[%0d]: got %h expected %h", c, mem_readdata, 32'((c - 2) * 3)); end
         end
         next_cycle();
      end
      mem_read = 0;
   endtask

   task automatic test_stall();
      mem_read = 1; mem_address = 32'h20;
      core_wr = 1; core_addr = 7'd8; core_wdata = 32'hA5A5_0008; ref_mem[8] = core_wdata;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk_sys);
         checks++;
         if (mem_waitrequest !== (k == 0)) begin errors++;
            $display("FAIL stall_wait[%0d]: got %b expected %b", k, mem_waitrequest, k == 0); end
         checks++;
         if (mem_readdatavalid !== (k == 3)) begin errors++;
            $display("FAIL stall_valid[%0d]: got %b expected %b", k, mem_readdatavalid, k == 3); end
         if (k == 3) begin
            checks++;
            if (mem_readdata !== 32'hA5A5_0008) begin errors++;
               $display("FAIL stall_data: got %h expected a5a50008", mem_readdata); end
         end
         next_cycle();
         core_wr = 0;
         if (k == 1) mem_read = 0;
      end
   endtask

   task automatic test_core_rw();
      logic [31:0] exp [5];
      exp[1] = ref_mem[77]; exp[2] = ref_mem[77]; exp[3] = 32'hDEAD_BEEF; exp[4] = 32'hDEAD_BEEF;
      for (int k = 0; k < 5; k++) begin
         core_rd = k <= 2;
         core_wr = k == 1;
         core_addr = (k == 0) ? 7'd77 : 7'd6;
         core_wdata = 32'hDEAD_BEEF;
         if (k == 1) ref_mem[6] = core_wdata;
         @(negedge clk_sys);
         if (k > 0) begin
            checks++;
            if (core_rdata !== exp[k]) begin errors++;
               $display("FAIL core_rdata[%0d]: got %h expected %h", k, core_rdata, exp[k]); end
         end
         next_cycle();
      end
      idle();
      exp_crd = 32'hDEAD_BEEF;
   endtask

   task automatic test_random();
      localparam int N = 400;
      int unsigned r;
      logic hold, exp_wait, exp_v;
      int due_q [$];
      logic [31:0] dat_q [$];
      hold = 0;
      for (int c = 0; c < N + 4; c++) begin
         if (!hold) begin
            mem_read = 0; mem_write = 0;
            if (c < N) begin
               r = $urandom_range(0, 5);
               mem_read = (r == 1 || r == 2 || r == 4);
               mem_write = (r == 3 || r == 4);
               mem_address = {23'd0, 7'($urandom_range(0, 127)), 2'b00};
               mem_writedata = $urandom;
               mem_byteenable = 4'($urandom);
            end
         end
         core_rd = 0; core_wr = 0;
         if (c < N) begin
            core_rd = $urandom_range(0, 3) == 0;
            core_wr = $urandom_range(0, 3) == 0;
            core_addr = 7'($urandom);
            core_wdata = $urandom;
         end
         exp_wait = (mem_read | mem_write) & (core_rd | core_wr);
         exp_v = due_q.size() > 0 && due_q[0] == c;
         @(negedge clk_sys);
         checks++;
         if (mem_waitrequest !== exp_wait) begin errors++;
            $display("FAIL rnd_wait[%0d]: got %b expected %b", c, mem_waitrequest, exp_wait); end
         checks++;
         if (mem_readdatavalid !== exp_v) begin errors++;
            $display("FAIL rnd_valid[%0d]: got %b expected %b", c, mem_readdatavalid, exp_v); end
         if (exp_v) begin
            checks++;
            if (mem_readdata !== dat_q[0]) begin errors++;
               $display("FAIL rnd_data[%0d]: got %h expected %h", c, mem_readdata, dat_q[0]); end
            void'(due_q.pop_front());
            void'(dat_q.pop_front());
         end
         checks++;
         if (core_rdata !== exp_crd) begin errors++;
            $display("FAIL rnd_core_rdata[%0d]: got %h expected %h", c, core_rdata, exp_crd); end
         if (core_rd && !core_wr) exp_crd = ref_mem[core_addr];
         if (core_wr) ref_mem[core_addr] = core_wdata;
         if (!exp_wait) begin
            if (mem_write) ref_write(mem_address, mem_writedata, mem_byteenable);
            else if (mem_read) begin due_q.push_back(c + 2); dat_q.push_back(ref_read(mem_address)); end
         end
         hold = exp_wait;
         next_cycle();
      end
      checks++;
      if (due_q.size() != 0) begin errors++; $display("FAIL rnd_drain: got %0d pending expected 0", due_q.size()); end
      checks++;
      if (oor_flag !== 1'b0) begin errors++; $display("FAIL rnd_oor: got %b expected 0", oor_flag); end
      idle();
   endtask

   task automatic test_disk_op();
      logic [3:0] exp;
      op_start = 1; op_write = 0; op_device = 1;
      @(negedge clk_sys);
      checks++;
      if (disk_op_read !== 1'b0) begin errors++; $display("FAIL op_early: got %b expected 0", disk_op_read); end
      next_cycle();
      op_start = 0;
      for (int k = 1; k <= 52; k++) begin
         disk_result_ok = k == 50;
         op_start = k == 10;
         op_write = k == 10;
         exp = {k <= 50, 1'b0, k == 51, 1'b0};
         @(negedge clk_sys);
         checks++;
         if ({disk_op_read, disk_op_write, op_done, op_err} !== exp) begin errors++;
            $display("FAIL op_read[%0d]: got %b expected %b", k, {disk_op_read, disk_op_write, op_done, op_err}, exp); end
         if (k == 1) begin
            checks++;
            if (disk_op_device !== 1'b1) begin errors++; $display("FAIL op_device: got %b expected 1", disk_op_device); end
         end
         next_cycle();
      end
      idle();
   endtask

   task automatic test_timeout();
      logic [3:0] exp_t, exp_d;
      op_start = 1; op_write = 1; op_device = 0;
      next_cycle();
      op_start = 0;
      for (int k = 1; k <= 24; k++) begin
         disk_result_ok = k == 20;
         exp_t = {k <= 16, 1'b0, k == 17, k == 17};
         exp_d = {k <= 20, 1'b0, k == 21, 1'b0};
         @(negedge clk_sys);
         checks++;
         if ({t_disk_op_write, t_disk_op_read, t_op_done, t_op_err} !== exp_t) begin errors++;
            $display("FAIL timeout[%0d]: got %b expected %b", k, {t_disk_op_write, t_disk_op_read, t_op_done, t_op_err}, exp_t); end
         checks++;
         if ({disk_op_write, disk_op_read, op_done, op_err} !== exp_d) begin errors++;
            $display("FAIL write_op[%0d]: got %b expected %b", k, {disk_op_write, disk_op_read, op_done, op_err}, exp_d); end
         next_cycle();
      end
      checks++;
      if ({disk_op_device, t_disk_op_device} !== 2'b00) begin errors++;
         $display("FAIL device_latch: got %b expected 00", {disk_op_device, t_disk_op_device}); end
      idle();
   endtask

   task automatic test_result_priority();
      logic [2:0] exp;
      logic [2:0] tbl [3];
      tbl[0] = 3'b111; tbl[1] = 3'b011; tbl[2] = 3'b100;
      for (int t = 0; t < 3; t++) begin
         op_start = 1; op_write = 0; op_device = 1;
         next_cycle();
         op_start = 0;
         for (int k = 1; k <= 4; k++) begin
            disk_result_ok = (k == 3) & tbl[t][2];
            disk_result_error = (k == 3) & tbl[t][1];
            exp = {k <= 3, k == 4, (k == 4) & tbl[t][0]};
            @(negedge clk_sys);
            checks++;
            if ({disk_op_read, op_done, op_err} !== exp) begin errors++;
               $display("FAIL result_prio[%0d/%0d]: got %b expected %b", t, k, {disk_op_read, op_done, op_err}, exp); end
            next_cycle();
         end
         idle();
      end
      disk_result_ok = 1;
      next_cycle();
      disk_result_ok = 0;
      @(negedge clk_sys);
      checks++;
      if ({disk_op_read, op_done} !== 2'b00) begin errors++;
         $display("FAIL idle_result: got %b expected 00", {disk_op_read, op_done}); end
      next_cycle();
   endtask

   task automatic test_oor();
      logic [31:0] exp;
      core_wr = 1; core_addr = 7'd0; core_wdata = 32'h5555_AAAA; ref_mem[0] = core_wdata;
      next_cycle();
      core_wr = 0;
      checks++;
      if (oor_flag !== 1'b0) begin errors++; $display("FAIL oor_pre: got %b expected 0", oor_flag); end
      mem_read = 1; mem_address = 32'h400;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk_sys);
         checks++;
         if ({mem_waitrequest, mem_readdatavalid} !== {1'b0, k == 2}) begin errors++;
            $display("FAIL oor_valid[%0d]: got %b expected %b", k, {mem_waitrequest, mem_readdatavalid}, {1'b0, k == 2}); end
         if (k == 2) begin
            checks++;
            if (mem_readdata !== 32'h0) begin errors++; $display("FAIL oor_data: got %h expected 0", mem_readdata); end
         end
         if (k >= 1) begin
            checks++;
            if (oor_flag !== 1'b1) begin errors++; $display("FAIL oor_flag[%0d]: got %b expected 1", k, oor_flag); end
         end
         next_cycle();
         mem_read = 0;
      end
      mem_write = 1; mem_address = 32'h210; mem_writedata = 32'hFFFF_FFFF; mem_byteenable = 4'hF;
      ref_write(mem_address, mem_writedata, mem_byteenable);
      next_cycle();
      mem_write = 0; mem_read = 1; mem_address = 32'h10;
      exp = ref_read(32'h10);
      next_cycle();
      mem_read = 0;
      next_cycle();
      @(negedge clk_sys);
      checks++;
      if ({mem_readdatavalid, mem_readdata} !== {1'b1, exp}) begin errors++;
         $display("FAIL oor_write_drop: got %b/%h expected 1/%h", mem_readdatavalid, mem_readdata, exp); end
      next_cycle();
   endtask

   task automatic test_reset_inflight();
      mem_read = 1; mem_address = 32'h0;
      next_cycle();
      mem_address = 32'h4;
      next_cycle();
      mem_read = 0;
      reset = 1;
      @(negedge clk_sys);
      checks++;
      if ({mem_readdatavalid, oor_flag, mem_readdata} !== 34'h0) begin errors++;
         $display("FAIL reset_async: got %b/%b/%h expected 0/0/0", mem_readdatavalid, oor_flag, mem_readdata); end
      next_cycle();
      reset = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk_sys);
         checks++;
         if ({mem_readdatavalid, oor_flag} !== 2'b00) begin errors++;
            $display("FAIL reset_inflight[%0d]: got %b expected 00", k, {mem_readdatavalid, oor_flag}); end
         next_cycle();
      end
   endtask

   task automatic test_burstcount();
      logic [31:0] exp;
      exp = ref_read(32'h8);
      mem_read = 1; mem_address = 32'h8; mem_burstcount = 0;
      next_cycle();
      idle();
      @(negedge clk_sys);
      checks++;
      if (oor_flag !== 1'b1) begin errors++; $display("FAIL burst_flag: got %b expected 1", oor_flag); end
      next_cycle();
      @(negedge clk_sys);
      checks++;
      if ({mem_readdatavalid, mem_readdata} !== {1'b1, exp}) begin errors++;
         $display("FAIL burst_data: got %b/%h expected 1/%h", mem_readdatavalid, mem_readdata, exp); end
      next_cycle();
   endtask

   initial begin
      test_reset();
      test_fill();
      test_byte_enable();
      test_back_to_back();
      test_stall();
      test_core_rw();
      test_random();
      test_disk_op();
      test_timeout();
      test_result_priority();
      test_oor();
      test_reset_inflight();
      test_burstcount();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
